// File: rtl/gat_ctrl_pkg.sv
// Shared types and constants for the GAT BRAM load/readback controller.
package gat_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bit positions inside err_flags = {bad_ch, overflow, misaligned}
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_BAD_CH   = 2;

  // Host addresses are byte addresses over 32-bit words
  localparam int BYTE_SHIFT = 2;

endpackage

// File: rtl/gat_ch_counter.sv
// Per-channel accepted-word counter: saturates at depth, optional clear-then-count,
// and flags the channel loaded once the count reaches a non-zero depth.
module gat_ch_counter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_depth,
  output logic              o_load_done
);

  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_count_next;

  // A clear and a write in the same cycle leave the count at one, not zero
  assign w_base       = i_clr ? '0 : r_count;
  assign w_count_next = (i_inc && (w_base < i_depth)) ? w_base + 1'b1 : w_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_load_done = (r_count == i_depth) && (i_depth != '0);

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// Host load/readback controller: routes host writes onto the core BRAMs, sequences a
// layer run, and returns feature data with a fixed-latency valid.
module gat_bram_load_ctrl
  import gat_ctrl_pkg::*;
#(
  parameter int  TOP_WIDTH  = 32,
  parameter int  NUM_CH     = 3,
  parameter int  CH_ADDR_W  = 18,
  parameter int  CH_DATA_W  = 20,
  parameter int  RD_ADDR_W  = 16,
  parameter int  RD_LATENCY = 2,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_wr_en,
  input  logic [SEL_W-1:0]            host_ch_sel,
  input  logic [CH_ADDR_W+1:0]        host_addr,
  input  logic [TOP_WIDTH-1:0]        host_din,
  input  logic [NUM_CH*CH_ADDR_W-1:0] ch_depth,
  input  logic [NUM_CH-1:0]           reload_mask,
  input  logic                        layer_in,
  output logic [NUM_CH-1:0]           bram_we,
  output logic [CH_ADDR_W-1:0]        bram_addr,
  output logic [CH_DATA_W-1:0]        bram_din,
  output logic [NUM_CH-1:0]           load_done,
  output logic                        gat_start,
  output logic                        gat_layer,
  input  logic                        core_done,
  output logic                        gat_ready,
  input  logic                        rd_en,
  input  logic [RD_ADDR_W+1:0]        rd_addr,
  output logic [RD_ADDR_W-1:0]        feat_addr,
  input  logic [TOP_WIDTH-1:0]        feat_dout,
  output logic                        rd_valid,
  output logic [TOP_WIDTH-1:0]        rd_data,
  output logic [2:0]                  err_flags
);

  state_t r_state, w_state_next;

  logic [CH_ADDR_W-1:0]  w_depth [NUM_CH];
  logic [NUM_CH-1:0]     w_ch_hit, w_inc, w_clr;
  logic [CH_ADDR_W-1:0]  w_word_addr, w_sel_depth;
  logic                  w_misaligned, w_bad_ch, w_overflow;
  logic                  w_wr_open, w_try, w_accept, w_all_loaded;

  logic [NUM_CH-1:0]     r_bram_we;
  logic [CH_ADDR_W-1:0]  r_bram_addr;
  logic [CH_DATA_W-1:0]  r_bram_din;
  logic [2:0]            r_err;
  logic                  r_gat_layer;
  logic [RD_LATENCY-1:0] r_vld_sr, r_gate_sr;
  logic                  w_unused;

  assign w_word_addr  = host_addr[CH_ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];
  assign w_misaligned = |host_addr[BYTE_SHIFT-1:0];
  assign w_bad_ch     = {1'b0, host_ch_sel} >= (SEL_W+1)'(NUM_CH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_depth[gi]  = ch_depth[gi*CH_ADDR_W +: CH_ADDR_W];
      assign w_ch_hit[gi] = (host_ch_sel == SEL_W'(gi));
      assign w_inc[gi]    = w_accept & w_ch_hit[gi];
      assign w_clr[gi]    = host_wr_en & (r_state == DONE) & reload_mask[gi];

      gat_ch_counter #(.ADDR_W(CH_ADDR_W)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr[gi]),
        .i_inc       (w_inc[gi]),
        .i_depth     (w_depth[gi]),
        .o_load_done (load_done[gi])
      );
    end
  endgenerate

  always_comb begin
    w_sel_depth = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_hit[c]) w_sel_depth = w_depth[c];
    end
  end

  // The core owns the BRAMs during START/RUN, so host writes there vanish without error
  assign w_overflow   = !w_bad_ch && (w_word_addr >= w_sel_depth);
  assign w_wr_open    = (r_state == IDLE) || (r_state == LOAD) || (r_state == DONE);
  assign w_try        = host_wr_en && w_wr_open;
  assign w_accept     = w_try && !w_misaligned && !w_bad_ch && !w_overflow;
  assign w_all_loaded = &load_done;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = LOAD;
      LOAD:    if (w_all_loaded) w_state_next = START;
      START:   w_state_next = RUN;
      RUN:     if (core_done) w_state_next = DONE;
      DONE:    if (host_wr_en) begin
                 w_state_next = (w_all_loaded && (reload_mask == '0)) ? START : LOAD;
               end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bram_we   <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_err       <= '0;
      r_gat_layer <= 1'b0;
      r_vld_sr    <= '0;
      r_gate_sr   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bram_we <= w_accept ? w_ch_hit : '0;
      if (w_accept) begin
        r_bram_addr <= w_word_addr;
        r_bram_din  <= host_din[CH_DATA_W-1:0];
      end
      if (w_try) begin
        r_err[ERR_BAD_CH]   <= r_err[ERR_BAD_CH]   | w_bad_ch;
        r_err[ERR_OVERFLOW] <= r_err[ERR_OVERFLOW] | w_overflow;
        r_err[ERR_MISALIGN] <= r_err[ERR_MISALIGN] | w_misaligned;
      end
      // Latch the layer as START is entered so it is stable alongside gat_start
      if ((r_state != START) && (w_state_next == START)) r_gat_layer <= layer_in;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_gate_sr[i] <= r_gate_sr[i-1];
      end
      r_vld_sr[0]  <= rd_en;
      r_gate_sr[0] <= (r_state == DONE);
    end
  end

  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;
  assign gat_start = (r_state == START);
  assign gat_layer = r_gat_layer;
  assign gat_ready = (r_state == DONE);
  assign err_flags = r_err;
  assign feat_addr = rd_addr[RD_ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];
  assign rd_valid  = r_vld_sr[RD_LATENCY-1];
  assign rd_data   = (r_vld_sr[RD_LATENCY-1] && r_gate_sr[RD_LATENCY-1]) ? feat_dout : '0;

  assign w_unused = ^{rd_addr[BYTE_SHIFT-1:0], host_din[TOP_WIDTH-1:CH_DATA_W]};

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Directed bench for gat_bram_load_ctrl with write/read scoreboards and a 2-cycle feature BRAM model.
module tb_gat_bram_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_en;
  logic [1:0]  host_ch_sel;
  logic [19:0] host_addr;
  logic [31:0] host_din;
  logic [53:0] ch_depth;
  logic [2:0]  reload_mask;
  logic        layer_in;
  logic [2:0]  bram_we;
  logic [17:0] bram_addr;
  logic [19:0] bram_din;
  logic [2:0]  load_done;
  logic        gat_start;
  logic        gat_layer;
  logic        core_done;
  logic        gat_ready;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [15:0] feat_addr;
  logic [31:0] feat_dout;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [2:0]  err_flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  we;
    logic [17:0] addr;
    logic [19:0] din;
  } wexp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rexp_t;

  wexp_t wr_q[$];
  rexp_t rd_q[$];

  logic [31:0] fmem [16];
  logic [31:0] fpipe1, fpipe2;

  gat_bram_load_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .host_wr_en  (host_wr_en),
    .host_ch_sel (host_ch_sel),
    .host_addr   (host_addr),
    .host_din    (host_din),
    .ch_depth    (ch_depth),
    .reload_mask (reload_mask),
    .layer_in    (layer_in),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .load_done   (load_done),
    .gat_start   (gat_start),
    .gat_layer   (gat_layer),
    .core_done   (core_done),
    .gat_ready   (gat_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .feat_addr   (feat_addr),
    .feat_dout   (feat_dout),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Feature BRAM model: address at cycle n, data visible during cycle n+2
  always @(posedge clk) begin
    fpipe1 <= fmem[feat_addr[3:0]];
    fpipe2 <= fpipe1;
  end
  assign feat_dout = fpipe2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wexp_t we_e;
    rexp_t re_e;
    if (!rst && (bram_we !== 3'b000)) begin
      if (wr_q.size() == 0) begin
        chk("unexp_we", 64'(bram_we), 64'd0);
      end else begin
        we_e = wr_q.pop_front();
        chk("we_lat", 64'(cyc - we_e.cyc), 64'd1);
        chk("we_vec", 64'(bram_we), 64'(we_e.we));
        chk("we_addr", 64'(bram_addr), 64'(we_e.addr));
        chk("we_din", 64'(bram_din), 64'(we_e.din));
      end
    end
    if (!rst && rd_valid) begin
      if (rd_q.size() == 0) begin
        chk("unexp_rd", 64'(rd_valid), 64'd0);
      end else begin
        re_e = rd_q.pop_front();
        chk("rd_lat", 64'(cyc - re_e.cyc), 64'd2);
        chk("rd_data", 64'(rd_data), 64'(re_e.data));
      end
    end
  end

  task automatic wr(input int ch, input int baddr, input logic [31:0] d, input bit acc);
    wexp_t e;
    host_wr_en  = 1'b1;
    host_ch_sel = ch[1:0];
    host_addr   = baddr[19:0];
    host_din    = d;
    if (acc) begin
      e.cyc  = cyc;
      e.we   = 3'(1 << ch);
      e.addr = 18'(baddr >> 2);
      e.din  = d[19:0];
      wr_q.push_back(e);
    end
    @(negedge clk);
    host_wr_en = 1'b0;
    chk("we_t1", 64'(bram_we), acc ? 64'(1 << ch) : 64'd0);
    $display("wr ch=%0d addr=%h din=%h expect_accept=%0d we=%b err=%b", ch, baddr, d, acc, bram_we, err_flags);
  endtask

  task automatic rd(input int baddr, input logic [31:0] exp);
    rexp_t e;
    rd_en   = 1'b1;
    rd_addr = baddr[17:0];
    e.cyc   = cyc;
    e.data  = exp;
    rd_q.push_back(e);
    #1;
    chk("feat_addr", 64'(feat_addr), 64'(baddr >> 2));
    $display("rd addr=%h expect=%h", baddr, exp);
    @(negedge clk);
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  task automatic pulse_core_done();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fmem[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
    rst         = 1'b1;
    host_wr_en  = 1'b0;
    host_ch_sel = '0;
    host_addr   = '0;
    host_din    = '0;
    ch_depth    = {18'd3, 18'd2, 18'd4};
    reload_mask = '0;
    layer_in    = 1'b0;
    core_done   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 64'({bram_we, load_done, gat_start, gat_layer, gat_ready, rd_valid, err_flags}), 64'd0);
    chk("reset_data", 64'({bram_addr, bram_din, rd_data}), 64'd0);

    // Dropped writes in IDLE: misaligned + bad channel, then overflow
    wr(3, 'h6, 32'h1111_1111, 1'b0);
    chk("err_bad_mis", 64'(err_flags), 64'b101);
    chk("ld_after_bad", 64'(load_done), 64'd0);
    wr(0, 'h10, 32'h2222_2222, 1'b0);
    chk("err_ovf", 64'(err_flags), 64'b111);
    chk("ld_after_ovf", 64'(load_done), 64'd0);

    // Full load: 4 + 2 + 3 words, data wider than 20 bits to exercise truncation
    for (int w = 0; w < 4; w++) wr(0, w * 4, 32'hABC0_0000 + 32'(w), 1'b1);
    chk("ld_ch0", 64'(load_done), 64'b001);
    for (int w = 0; w < 2; w++) wr(1, w * 4, 32'h5550_1000 + 32'(w), 1'b1);
    chk("ld_ch01", 64'(load_done), 64'b011);
    for (int w = 0; w < 3; w++) wr(2, w * 4, 32'hFFFF_F000 + 32'(w), 1'b1);
    chk("ld_all", 64'(load_done), 64'b111);
    chk("start_early", 64'(gat_start), 64'd0);
    @(negedge clk);
    chk("start_pulse", 64'(gat_start), 64'd1);
    @(negedge clk);
    chk("start_once", 64'(gat_start), 64'd0);
    chk("layer0", 64'(gat_layer), 64'd0);

    // RUN: host writes vanish without error, reads return zero data
    wr(0, 'h0, 32'h3333_3333, 1'b0);
    chk("err_run", 64'(err_flags), 64'b111);
    rd('h0, 32'h0);
    chk("ready_run", 64'(gat_ready), 64'd0);
    pulse_core_done();
    chk("ready_done", 64'(gat_ready), 64'd1);

    // Back-to-back readback in DONE
    rd('h0, fmem[0]);
    rd('h4, fmem[1]);
    rd('h8, fmem[2]);
    repeat (3) @(negedge clk);

    // Partial reload of channel 2 with a new layer
    reload_mask = 3'b100;
    layer_in    = 1'b1;
    wr(2, 'h0, 32'h0007_0000, 1'b1);
    chk("reload_ld", 64'(load_done), 64'b011);
    wr(2, 'h4, 32'h0007_0001, 1'b1);
    wr(2, 'h8, 32'h0007_0002, 1'b1);
    chk("reload_all", 64'(load_done), 64'b111);
    @(negedge clk);
    chk("start2", 64'(gat_start), 64'd1);
    @(negedge clk);
    chk("layer1", 64'(gat_layer), 64'd1);
    pulse_core_done();
    chk("ready2", 64'(gat_ready), 64'd1);

    // DONE, everything loaded, no reload: write goes straight to START
    reload_mask = 3'b000;
    layer_in    = 1'b0;
    wr(0, 'h0, 32'h0000_0ABC, 1'b1);
    chk("direct_start", 64'(gat_start), 64'd1);
    chk("ld_kept", 64'(load_done), 64'b111);
    @(negedge clk);
    chk("layer_back0", 64'(gat_layer), 64'd0);
    chk("run3", 64'(gat_start), 64'd0);

    // Reset in RUN aborts everything
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctl", 64'({bram_we, load_done, gat_start, gat_layer, gat_ready, rd_valid, err_flags}), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    pulse_core_done();
    chk("idle_ignores_done", 64'(gat_ready), 64'd0);

    repeat (3) @(negedge clk);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
